// File: rtl/wb_mailbox_device_if.sv
// wb_mailbox_device_if: Wishbone classic bus between controller and mailbox device
interface wb_mailbox_device_if #(parameter int DAT_WIDTH = 8);
  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [DAT_WIDTH-1:0] dat_i;
  logic [DAT_WIDTH-1:0] dat_o;
  logic                 ack_o;
  logic                 err_o;
  logic                 rty_o;
  modport master (output cyc_i, stb_i, we_i, dat_i, input dat_o, ack_o, err_o, rty_o);
  modport slave (input cyc_i, stb_i, we_i, dat_i, output dat_o, ack_o, err_o, rty_o);
endinterface

// File: rtl/wb_mailbox_device.sv
// wb_mailbox_device: Wishbone mailbox bridging bus writes to a TX stream and an RX stream to bus reads.
// Define WB_MAILBOX_ASYNC_ACK_EN for a combinational same-cycle response; default is a registered response.
module wb_mailbox_device #(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  wb_mailbox_device_if.slave     bus,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [DAT_WIDTH-1:0]   tx_data_o,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic [DAT_WIDTH-1:0]   rx_data_i,
  output logic [$clog2(DEPTH):0] tx_level_o,
  output logic [$clog2(DEPTH):0] rx_level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DAT_WIDTH-1:0] tx_mem [DEPTH];
  logic [DAT_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [LW-1:0] tx_level, rx_level;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
  logic req, ok, wr_ok, rd_ok;
  assign tx_full = tx_level == LW'(DEPTH);
  assign tx_empty = tx_level == '0;
  assign rx_full = rx_level == LW'(DEPTH);
  assign rx_empty = rx_level == '0;
  assign tx_pop = !tx_empty && tx_ready_i;
  assign rx_push = rx_valid_i && !rx_full;
  assign tx_valid_o = !tx_empty;
  assign tx_data_o = tx_mem[tx_rd];
  assign rx_ready_o = !rx_full;
  assign tx_level_o = tx_level;
  assign rx_level_o = rx_level;
  assign bus.err_o = 1'b0;
  assign ok = bus.we_i ? !tx_full : !rx_empty;
`ifdef WB_MAILBOX_ASYNC_ACK_EN
  assign req = bus.cyc_i && bus.stb_i;
  assign bus.ack_o = req && ok;
  assign bus.rty_o = req && !ok;
  assign bus.dat_o = rx_mem[rx_rd];
  assign wr_ok = bus.ack_o && bus.we_i;
  assign rd_ok = bus.ack_o && !bus.we_i;
`else
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic ack_sel, ack_sel_nx;
  logic [DAT_WIDTH-1:0] dat_q;
  assign req = bus.cyc_i && bus.stb_i && state == IDLE;
  assign wr_ok = req && bus.we_i && ok;
  assign rd_ok = req && !bus.we_i && ok;
  assign bus.ack_o = state == RESP && ack_sel;
  assign bus.rty_o = state == RESP && !ack_sel;
  assign bus.dat_o = dat_q;
  // Next state: a request opens one response cycle, which always closes the next edge
  always_comb begin
    state_nx = IDLE;
    ack_sel_nx = ack_sel;
    if (req) begin
      state_nx = RESP;
      ack_sel_nx = ok;
    end
  end
  // Response state, ack-vs-rty select and captured read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ack_sel <= 1'b0;
      dat_q <= '0;
    end else begin
      state <= state_nx;
      ack_sel <= ack_sel_nx;
      if (rd_ok) dat_q <= rx_mem[rx_rd];
    end
  end
`endif
  // FIFO storage; contents need no reset since pointers and levels gate visibility
  always_ff @(posedge clk_i) begin
    if (wr_ok) tx_mem[tx_wr] <= bus.dat_i;
    if (rx_push) rx_mem[rx_wr] <= rx_data_i;
  end
  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
      tx_level <= '0;
      rx_level <= '0;
    end else begin
      if (wr_ok) tx_wr <= tx_wr + AW'(1);
      if (tx_pop) tx_rd <= tx_rd + AW'(1);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rd_ok) rx_rd <= rx_rd + AW'(1);
      tx_level <= tx_level + LW'(wr_ok) - LW'(tx_pop);
      rx_level <= rx_level + LW'(rx_push) - LW'(rd_ok);
    end
  end
endmodule

// File: tb/tb_wb_mailbox_device.sv
// tb_wb_mailbox_device: directed bench with a queue-based model checked every cycle
module tb_wb_mailbox_device;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_ready = 1'b0;
  logic rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic tx_valid, rx_ready;
  logic [DW-1:0] tx_data;
  logic [LW-1:0] tx_level, rx_level;
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] tx_q [$];
  logic [DW-1:0] rx_q [$];
  bit m_resp, m_ack, m_we;
  logic [DW-1:0] m_dat;

  wb_mailbox_device_if #(.DAT_WIDTH(DW)) bus();

  wb_mailbox_device #(.DAT_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
    .tx_level_o(tx_level), .rx_level_o(rx_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: two queues plus the pending bus response
  always @(posedge clk or negedge rst_n) begin
    bit req, ok, tpop, rpush;
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      m_resp = 0;
      m_ack = 0;
      m_we = 0;
      m_dat = '0;
    end else begin
`ifdef WB_MAILBOX_ASYNC_ACK_EN
      req = bus.cyc_i && bus.stb_i;
`else
      req = bus.cyc_i && bus.stb_i && !m_resp;
`endif
      ok = bus.we_i ? tx_q.size() < DEPTH : rx_q.size() > 0;
      tpop = tx_q.size() > 0 && tx_ready;
      rpush = rx_valid && rx_q.size() < DEPTH;
      if (tpop) void'(tx_q.pop_front());
      if (req && bus.we_i && ok) tx_q.push_back(bus.dat_i);
      if (req && !bus.we_i && ok) m_dat = rx_q.pop_front();
      if (rpush) rx_q.push_back(rx_data);
      m_resp = req;
      m_ack = ok;
      m_we = bus.we_i;
    end
  end

  // Compare all outputs against the model on every cycle outside reset
  always @(negedge clk) begin
    bit e_ack, e_rty, e_we;
    logic [DW-1:0] e_dat;
`ifdef WB_MAILBOX_ASYNC_ACK_EN
    bit ok;
`endif
    if (rst_n) begin
`ifdef WB_MAILBOX_ASYNC_ACK_EN
      ok = bus.we_i ? tx_q.size() < DEPTH : rx_q.size() > 0;
      e_ack = bus.cyc_i && bus.stb_i && ok;
      e_rty = bus.cyc_i && bus.stb_i && !ok;
      e_we = bus.we_i;
      e_dat = rx_q.size() > 0 ? rx_q[0] : '0;
`else
      e_ack = m_resp && m_ack;
      e_rty = m_resp && !m_ack;
      e_we = m_we;
      e_dat = m_dat;
`endif
      check("ack_o", 32'(bus.ack_o), 32'(e_ack));
      check("rty_o", 32'(bus.rty_o), 32'(e_rty));
      check("err_o", 32'(bus.err_o), 32'd0);
      if (e_ack && !e_we) check("dat_o", 32'(bus.dat_o), 32'(e_dat));
      check("tx_level", 32'(tx_level), tx_q.size());
      check("rx_level", 32'(rx_level), rx_q.size());
      check("tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
      check("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
      if (tx_q.size() > 0) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transfer; returns with the response cycle's outputs captured
  task automatic xfer(input bit we, input logic [DW-1:0] d, output bit ak, output bit rt, output logic [DW-1:0] q);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i = we;
    bus.dat_i = d;
`ifdef WB_MAILBOX_ASYNC_ACK_EN
    @(negedge clk);
    ak = bus.ack_o;
    rt = bus.rty_o;
    q = bus.dat_o;
    tick();
`else
    tick();
    ak = bus.ack_o;
    rt = bus.rty_o;
    q = bus.dat_o;
`endif
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    bit ak, rt;
    logic [DW-1:0] q;
    xfer(1'b1, d, ak, rt, q);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ak, rt;
    logic [DW-1:0] q, e;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i = 1'b0;
    bus.dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_rty", 32'(bus.rty_o), 32'd0);
    check("rst_dat", 32'(bus.dat_o), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    rst_n = 1'b1;
    tick();
    // Single write then stream drain
    xfer(1'b1, 8'hA5, ak, rt, q);
    check("wr_a5_ack", 32'(ak), 32'd1);
    check("wr_a5_rty", 32'(rt), 32'd0);
    check("wr_a5_level", 32'(tx_level), 32'd1);
    check("wr_a5_valid", 32'(tx_valid), 32'd1);
    check("wr_a5_data", 32'(tx_data), 32'hA5);
    tick();
    tx_ready = 1'b1;
    tick();
    check("wr_a5_drained", 32'(tx_level), 32'd0);
    tx_ready = 1'b0;
    // TX full
    for (int i = 1; i <= 4; i++) wr(8'(i));
    xfer(1'b1, 8'h05, ak, rt, q);
    check("full_ack", 32'(ak), 32'd0);
    check("full_rty", 32'(rt), 32'd1);
    check("full_level", 32'(tx_level), 32'd4);
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 32'(tx_data), 32'(i + 1));
      tick();
    end
    tx_ready = 1'b0;
    check("drain_empty", 32'(tx_level), 32'd0);
    // RX read
    rx_valid = 1'b1;
    rx_data = 8'h3C;
    tick();
    rx_data = 8'hC3;
    tick();
    rx_valid = 1'b0;
    check("rx_level2", 32'(rx_level), 32'd2);
    xfer(1'b0, '0, ak, rt, q);
    check("rd1_ack", 32'(ak), 32'd1);
    check("rd1_dat", 32'(q), 32'h3C);
    tick();
    xfer(1'b0, '0, ak, rt, q);
    check("rd2_ack", 32'(ak), 32'd1);
    check("rd2_dat", 32'(q), 32'hC3);
    tick();
    xfer(1'b0, '0, ak, rt, q);
    check("rd3_ack", 32'(ak), 32'd0);
    check("rd3_rty", 32'(rt), 32'd1);
    tick();
    // RX fill: ready drops only at level 4
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'h40 + i);
      check("fill_ready", 32'(rx_ready), 32'(i < 4));
      tick();
    end
    rx_valid = 1'b0;
    check("fill_level", 32'(rx_level), 32'd4);
    check("fill_ready_low", 32'(rx_ready), 32'd0);
    xfer(1'b0, '0, ak, rt, q);
    check("full_rd_dat", 32'(q), 32'h40);
    check("full_rd_ready", 32'(rx_ready), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, '0, ak, rt, q);
      check("rx_drain", 32'(q), 32'(8'h41 + i));
      tick();
    end
    // Simultaneous bus push and stream pop
    wr(8'h10);
    wr(8'h20);
    check("simul_pre", 32'(tx_level), 32'd2);
    tx_ready = 1'b1;
    xfer(1'b1, 8'h30, ak, rt, q);
    tx_ready = 1'b0;
    check("simul_ack", 32'(ak), 32'd1);
    check("simul_level", 32'(tx_level), 32'd2);
    check("simul_head", 32'(tx_data), 32'h20);
    tick();
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    check("simul_drained", 32'(tx_level), 32'd0);
    // Reset during the response
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i = 1'b1;
    bus.dat_i = 8'h77;
    tick();
    check("mid_ack", 32'(bus.ack_o), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    #1;
    check("mid_rst_ack", 32'(bus.ack_o), 32'd0);
    check("mid_rst_tx_level", 32'(tx_level), 32'd0);
    check("mid_rst_rx_level", 32'(rx_level), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_level", 32'(tx_level), 32'd0);
    check("post_rst_valid", 32'(tx_valid), 32'd0);
`ifdef WB_MAILBOX_ASYNC_ACK_EN
    // Back-to-back single-cycle reads
    rx_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rx_data = 8'(17 * i);
      tick();
    end
    rx_valid = 1'b0;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      e = 8'(17 * i);
      check("b2b_ack", 32'(bus.ack_o), 32'd1);
      check("b2b_dat", 32'(bus.dat_o), 32'(e));
      tick();
    end
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    check("b2b_level", 32'(rx_level), 32'd0);
`else
    e = '0;
`endif
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
